// File: rtl/store_seq_ctrl_pkg.sv
// Shared store opcode encodings, controller state encoding and the per-op base byte mask.
package store_seq_ctrl_pkg;

  localparam int STORE_OP_WIDTH = 2;

  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 2'b00;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 2'b01;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2
  } state_t;

  // Unknown opcodes map to an empty mask, which marks them as no-ops.
  function automatic logic [3:0] storeBaseMask(input logic [STORE_OP_WIDTH-1:0] op);
    case (op)
      STORE_OP_SB: storeBaseMask = 4'b0001;
      STORE_OP_SH: storeBaseMask = 4'b0011;
      STORE_OP_SW: storeBaseMask = 4'b1111;
      default:     storeBaseMask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/store_seq_ctrl_lane_shift.sv
// store_lane_shift: positions store data and byte mask into a two-word (64-bit) lane view.
module store_lane_shift
  import store_seq_ctrl_pkg::*;
(
  input  logic [STORE_OP_WIDTH-1:0] i_op,
  input  logic [1:0]                i_offset,
  input  logic [31:0]               i_data,
  output logic [63:0]               o_wideData,
  output logic [7:0]                o_wideMask,
  output logic                      o_split
);

  logic [63:0] w_shiftedData;
  logic [63:0] w_byteEnable;

  assign o_wideMask    = {4'b0000, storeBaseMask(i_op)} << i_offset;
  assign w_shiftedData = {32'b0, i_data} << {i_offset, 3'b000};
  assign o_split       = |o_wideMask[7:4];

  // Bytes of req_data above the store width must not leak onto disabled lanes.
  always_comb begin
    w_byteEnable = '0;
    for (int i = 0; i < 8; i++) begin
      w_byteEnable[i*8 +: 8] = {8{o_wideMask[i]}};
    end
  end

  assign o_wideData = w_shiftedData & w_byteEnable;

endmodule

// File: rtl/store_seq_ctrl.sv
// Store sequencer: turns SB/SH/SW requests into word-bus writes with a done pulse.
// Build option STORE_MISALIGN_SPLIT_EN: split word-crossing stores into two writes; otherwise fault.
module store_seq_ctrl
  import store_seq_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [STORE_OP_WIDTH-1:0] req_op,
  input  logic [31:0]               req_data,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wmask,
  output logic                      done,
  output logic                      fault
);

  state_t r_state;
  state_t w_nextState;

  logic [63:0]           w_wideData;
  logic [7:0]            w_wideMask;
  logic                  w_split;
  logic                  w_validOp;
  logic                  w_reject;
  logic                  w_accept;
  logic                  w_handshake;
  logic                  w_lastBeat;

  logic                  r_memValid;
  logic [ADDR_WIDTH-1:0] r_memAddr;
  logic [31:0]           r_memWdata;
  logic [3:0]            r_memWmask;
  logic                  r_done;
  logic                  r_fault;

  store_lane_shift u_laneShift (
    .i_op       (req_op),
    .i_offset   (req_addr[1:0]),
    .i_data     (req_data),
    .o_wideData (w_wideData),
    .o_wideMask (w_wideMask),
    .o_split    (w_split)
  );

  assign w_validOp   = |w_wideMask;
  assign w_handshake = r_memValid && mem_ready;

`ifdef STORE_MISALIGN_SPLIT_EN
  logic [31:0] r_hiData;
  logic [3:0]  r_hiMask;
  logic        r_split;

  assign w_reject   = 1'b0;
  assign w_lastBeat = !((r_state == WR0) && r_split);
`else
  logic w_unusedHi;

  assign w_reject   = w_split;
  assign w_lastBeat = 1'b1;
  assign w_unusedHi = ^{w_wideData[63:32], w_wideMask[7:4]};
`endif

  // Next-state logic; no-ops and rejected requests are consumed without leaving IDLE.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (w_validOp && !w_reject) begin
            w_nextState = WR0;
          end
        end
      end
      WR0: begin
        if (w_handshake) begin
          w_nextState = w_lastBeat ? IDLE : WR1;
        end
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      WR1: begin
        if (w_handshake) begin
          w_nextState = IDLE;
        end
      end
`endif
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_memValid <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_memWmask <= '0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      r_hiData   <= '0;
      r_hiMask   <= '0;
      r_split    <= 1'b0;
`endif
    end else begin
      r_state <= w_nextState;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      if (w_accept) begin
        if (!w_validOp) begin
          r_done <= 1'b1;
        end else if (w_reject) begin
          r_fault <= 1'b1;
        end else begin
          r_memValid <= 1'b1;
          r_memAddr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          r_memWdata <= w_wideData[31:0];
          r_memWmask <= w_wideMask[3:0];
`ifdef STORE_MISALIGN_SPLIT_EN
          r_hiData   <= w_wideData[63:32];
          r_hiMask   <= w_wideMask[7:4];
          r_split    <= w_split;
`endif
        end
      end else if (w_handshake && w_lastBeat) begin
        r_memValid <= 1'b0;
        r_memAddr  <= '0;
        r_memWdata <= '0;
        r_memWmask <= '0;
        r_done     <= 1'b1;
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      // Second beat follows immediately; address wraps naturally at the top of memory.
      else if (w_handshake) begin
        r_memAddr  <= r_memAddr + ADDR_WIDTH'(4);
        r_memWdata <= r_hiData;
        r_memWmask <= r_hiMask;
      end
`endif
    end
  end

  assign req_ready = (r_state == IDLE);
  assign mem_valid = r_memValid;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign mem_wmask = r_memWmask;
  assign done      = r_done;
  assign fault     = r_fault;

endmodule

// File: tb/tb_store_seq_ctrl.sv
// Self-checking bench for store_seq_ctrl: table of single-beat stores plus hand-written corner sequences.
module tb_store_seq_ctrl;
  import store_seq_ctrl_pkg::*;

  logic                      clk;
  logic                      rst;
  logic                      req_valid;
  logic                      req_ready;
  logic [31:0]               req_addr;
  logic [STORE_OP_WIDTH-1:0] req_op;
  logic [31:0]               req_data;
  logic                      mem_valid;
  logic                      mem_ready;
  logic [31:0]               mem_addr;
  logic [31:0]               mem_wdata;
  logic [3:0]                mem_wmask;
  logic                      done;
  logic                      fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [STORE_OP_WIDTH-1:0] op;
    logic [31:0]               addr;
    logic [31:0]               data;
    bit                        expWrite;
    logic [31:0]               expAddr;
    logic [31:0]               expData;
    logic [3:0]                expMask;
  } vec_t;

  vec_t vecs[7];

  store_seq_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_op    (req_op),
    .req_data  (req_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .done      (done),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Presents one request for a single cycle; returns at the negedge after the accept edge (cycle 1).
  task automatic applyStimulus(input logic [STORE_OP_WIDTH-1:0] op, input logic [31:0] addr,
                               input logic [31:0] data);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    checkOutput("req_ready_at_accept", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic checkBeat(input string name, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] mask);
    checkOutput({name, "_valid"}, mem_valid, 1);
    checkOutput({name, "_addr"}, mem_addr, addr);
    checkOutput({name, "_wdata"}, mem_wdata, data);
    checkOutput({name, "_wmask"}, mem_wmask, mask);
    checkOutput({name, "_ready_busy"}, req_ready, 0);
  endtask

  task automatic checkRejected(input string name);
    checkOutput({name, "_novalid"}, mem_valid, 0);
    checkOutput({name, "_fault"}, fault, 1);
    checkOutput({name, "_nodone"}, done, 0);
    checkOutput({name, "_ready"}, req_ready, 1);
    @(negedge clk);
    checkOutput({name, "_fault_pulse"}, fault, 0);
  endtask

  initial begin
    vecs[0] = '{STORE_OP_SB, 32'h0000_1003, 32'h0000_00A5, 1'b1, 32'h0000_1000, 32'hA500_0000, 4'b1000};
    vecs[1] = '{STORE_OP_SH, 32'h0000_2002, 32'h0000_1234, 1'b1, 32'h0000_2000, 32'h1234_0000, 4'b1100};
    vecs[2] = '{STORE_OP_SW, 32'h0000_3000, 32'hDDCC_BBAA, 1'b1, 32'h0000_3000, 32'hDDCC_BBAA, 4'b1111};
    vecs[3] = '{STORE_OP_SB, 32'h0000_0010, 32'hFFFF_FF5A, 1'b1, 32'h0000_0010, 32'h0000_005A, 4'b0001};
    vecs[4] = '{STORE_OP_SH, 32'h0000_0021, 32'hABCD_1234, 1'b1, 32'h0000_0020, 32'h0012_3400, 4'b0110};
    vecs[5] = '{STORE_OP_SB, 32'h8000_0032, 32'h0000_0077, 1'b1, 32'h8000_0030, 32'h0077_0000, 4'b0100};
    vecs[6] = '{2'b11,       32'h0000_0044, 32'h1234_5678, 1'b0, 32'h0,        32'h0,         4'b0000};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_data  = '0;
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", req_ready, 1);
    checkOutput("reset_valid", mem_valid, 0);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_wdata", mem_wdata, 0);
    checkOutput("reset_wmask", mem_wmask, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_fault", fault, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready_ignored", mem_valid, 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].data);
      if (vecs[i].expWrite) begin
        checkBeat($sformatf("vec%0d", i), vecs[i].expAddr, vecs[i].expData, vecs[i].expMask);
        checkOutput($sformatf("vec%0d_nodone_c1", i), done, 0);
        @(negedge clk);
      end
      checkOutput($sformatf("vec%0d_done", i), done, 1);
      checkOutput($sformatf("vec%0d_valid_low", i), mem_valid, 0);
      checkOutput($sformatf("vec%0d_nofault", i), fault, 0);
      checkOutput($sformatf("vec%0d_ready_with_done", i), req_ready, 1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // Word-crossing word store.
    applyStimulus(STORE_OP_SW, 32'h0000_3001, 32'hDDCC_BBAA);
`ifdef STORE_MISALIGN_SPLIT_EN
    checkBeat("split_b0", 32'h0000_3000, 32'hCCBB_AA00, 4'b1110);
    @(negedge clk);
    checkBeat("split_b1", 32'h0000_3004, 32'h0000_00DD, 4'b0001);
    checkOutput("split_nodone_c2", done, 0);
    @(negedge clk);
    checkOutput("split_done", done, 1);
    checkOutput("split_valid_low", mem_valid, 0);
`else
    checkRejected("split_off");
`endif

    // Backpressure on an aligned store: outputs hold while stalled.
    mem_ready = 1'b0;
    applyStimulus(STORE_OP_SW, 32'h0000_4000, 32'hCAFE_F00D);
    for (int s = 0; s < 3; s++) begin
      checkBeat($sformatf("stall_al_%0d", s), 32'h0000_4000, 32'hCAFE_F00D, 4'b1111);
      checkOutput($sformatf("stall_al_nodone_%0d", s), done, 0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    checkBeat("stall_al_final", 32'h0000_4000, 32'hCAFE_F00D, 4'b1111);
    @(negedge clk);
    checkOutput("stall_al_done", done, 1);
    @(negedge clk);
    checkOutput("stall_al_done_pulse", done, 0);

`ifdef STORE_MISALIGN_SPLIT_EN
    // Backpressure on both beats of a split halfword.
    mem_ready = 1'b0;
    applyStimulus(STORE_OP_SH, 32'h0000_4003, 32'h0000_BEEF);
    for (int s = 0; s < 3; s++) begin
      checkBeat($sformatf("stall_sp0_%0d", s), 32'h0000_4000, 32'hEF00_0000, 4'b1000);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      checkBeat($sformatf("stall_sp1_%0d", s), 32'h0000_4004, 32'h0000_00BE, 4'b0001);
      checkOutput($sformatf("stall_sp1_nodone_%0d", s), done, 0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_sp_done", done, 1);
    @(negedge clk);
    checkOutput("stall_sp_done_once", done, 0);
`endif

    // Misaligned word at a half offset.
    applyStimulus(STORE_OP_SW, 32'h0000_5002, 32'h0102_0304);
`ifdef STORE_MISALIGN_SPLIT_EN
    checkBeat("sw5002_b0", 32'h0000_5000, 32'h0304_0000, 4'b1100);
    @(negedge clk);
    checkBeat("sw5002_b1", 32'h0000_5004, 32'h0000_0102, 4'b0011);
    @(negedge clk);
    checkOutput("sw5002_done", done, 1);
`else
    checkRejected("sw5002_off");
`endif

    // Asynchronous reset while the first beat is stalled.
    mem_ready = 1'b0;
    applyStimulus(STORE_OP_SW, 32'h0000_6000, 32'h1111_2222);
    checkBeat("pre_reset", 32'h0000_6000, 32'h1111_2222, 4'b1111);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_valid", mem_valid, 0);
    checkOutput("midrst_addr", mem_addr, 0);
    checkOutput("midrst_wdata", mem_wdata, 0);
    checkOutput("midrst_wmask", mem_wmask, 0);
    checkOutput("midrst_ready", req_ready, 1);
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    checkOutput("postrst_done", done, 0);
    checkOutput("postrst_valid", mem_valid, 0);

    // Top-of-memory word store wraps its second beat to address 0.
    applyStimulus(STORE_OP_SW, 32'hFFFF_FFFE, 32'h1122_3344);
`ifdef STORE_MISALIGN_SPLIT_EN
    checkBeat("wrap_b0", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
    @(negedge clk);
    checkBeat("wrap_b1", 32'h0000_0000, 32'h0000_1122, 4'b0011);
    @(negedge clk);
    checkOutput("wrap_done", done, 1);
`else
    checkRejected("wrap_off");
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_seq_ctrl.md
Name: store_seq_ctrl

Overview:
- Sequences CPU store requests onto the word-wide memory bus.
- Computes the byte-lane data and write mask for SB/SH/SW.
- Splits misaligned SH/SW that cross a word boundary into two word transactions.
- Sits between the multicycle control FSM (request side) and the memory/bus interface; returns a one-cycle completion pulse.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- STORE_OP_WIDTH, taken from the shared defines, width of the store opcode (SB/SH/SW encodings).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  controller idle; request is accepted when req_valid && req_ready.
- req_addr  input  ADDR_WIDTH  byte address.
- req_op  input  STORE_OP_WIDTH  SB, SH or SW.
- req_data  input  32  store data, LSB-justified.
- mem_valid  output  1  bus write request.
- mem_ready  input  1  bus accepts the write when mem_valid && mem_ready.
- mem_addr  output  ADDR_WIDTH  word-aligned address; bits [1:0] are always 0.
- mem_wdata  output  32  lane-positioned write data.
- mem_wmask  output  4  byte enables.
- done  output  1  one-cycle pulse after the final bus handshake.
- fault  output  1  one-cycle pulse when a misaligned request is rejected (feature off only).

Behaviour:
- Reset values: req_ready=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wmask=0, done=0, fault=0, state=IDLE. Reset may arrive mid-transaction; the store in flight is abandoned and the controller returns to IDLE.
- Lane math is a 64-bit view with o=req_addr[1:0]:
  - wide_data = {32'b0, req_data} << (8*o).
  - wide_mask = {4'b0, base} << o, where base is 0001 for SB, 0011 for SH, 1111 for SW.
  - The request is split when wide_mask[7:4] != 0. This holds for SH with o=3 and for SW with o!=0. SB never splits.
- Lanes that are not enabled are driven 0, never X.
- An unknown req_op is accepted as a no-op: no bus write, done pulses in the cycle after acceptance.
- State machine:
  - IDLE: req_ready=1. On accept, register the lane data and mask, then go to WR0. On the accept edge, mem_valid rises: it is visible the cycle after acceptance.
  - WR0: mem_addr={addr[31:2],2'b00}, wdata=wide_data[31:0], wmask=wide_mask[3:0]. Hold all outputs stable until mem_ready. On handshake, go to WR1 if split, else to IDLE with done=1 for the next cycle.
  - WR1: mem_addr = WR0 address + 4, with 32-bit wrap (0xFFFFFFFC -> 0x00000000). wdata=wide_data[63:32], wmask=wide_mask[7:4]. On handshake, go to IDLE and pulse done.
- Handshake rules:
  - mem_valid never drops without a handshake.
  - Between WR0 and WR1, mem_valid stays high; a back-to-back second write is allowed with no bubble.
  - mem_ready while mem_valid=0 is ignored.
- req_ready=0 in every state except IDLE. A new request can be accepted in the same cycle done is high, because the controller is already in IDLE.
- Latency with mem_ready tied high:
  - Aligned store: accept at cycle 0, write at cycle 1, done at cycle 2.
  - Split store: writes at cycles 1 and 2, done at cycle 3.

Optional Feature:
- Macro: STORE_MISALIGN_SPLIT_EN.
- Defined: splitting works as described above.
- Undefined:
  - A request with wide_mask[7:4] != 0 is accepted, issues no bus write, and pulses fault (not done) the cycle after acceptance.
  - Aligned requests behave identically in both builds.
  - The WR1 state and the +4 adder are not built.

Decomposition:
- Shared defines/package: STORE_OP_SB/SH/SW encodings, STORE_OP_WIDTH, state encoding constants (IDLE, WR0, WR1).
- One combinational sub-module, store_lane_shift: inputs (op, offset, data), outputs the 64-bit wide_data, the 8-bit wide_mask and the split flag.
- The FSM and registers stay in store_seq_ctrl.

Test Plan:
- Byte store: SB, addr 0x1003, data 0xA5, mem_ready=1 -> one write: addr 0x1000, wmask 1000, wdata 0xA5000000; done at cycle 2.
- Half store, aligned: SH, addr 0x2002, data 0x1234 -> one write: addr 0x2000, wmask 1100, wdata 0x12340000.
- Word store, misaligned (feature on): SW, addr 0x3001, data 0xDDCCBBAA -> first write: addr 0x3000, wmask 1110, wdata 0xCCBBAA00; second write: addr 0x3004, wmask 0001, wdata 0x000000DD; done at cycle 3.
- Bus backpressure: SH, addr 0x4003, data 0xBEEF, mem_ready low for 3 cycles on each beat -> outputs stay stable while stalled; first write wmask 1000 with wdata[31:24]=0xEF; second write addr 0x4004, wmask 0001, data 0xBE; one done pulse.
- Feature off: SW, addr 0x5002 -> no mem_valid; fault pulses one cycle; req_ready returns to 1.
- Reset mid-operation and wrap: assert rst during WR0 -> all outputs reset immediately. Then SW at 0xFFFFFFFE -> second write addr 0x00000000, wmask 0011.
